// File: rtl/mdu_sequencer_if.sv
// Bundle of signals between E-stage MDU decode and the multiply/divide
// sequencer: operation request, mthi/mtlo write strobe and the HI/LO results.
interface mdu_sequencer_if;
    logic        START;
    logic [1:0]  MDU_OP;
    logic        madd;
    logic        WRITE_ENABLED;
    logic        HiLo;
    logic [31:0] A;
    logic [31:0] B;
    logic        BUSY;
    logic [31:0] HI;
    logic [31:0] LO;

    // Decode side: issues requests and reads back HI/LO.
    modport master (
        output START, MDU_OP, madd, WRITE_ENABLED, HiLo, A, B,
        input  BUSY, HI, LO
    );

    // Sequencer side.
    modport slave (
        input  START, MDU_OP, madd, WRITE_ENABLED, HiLo, A, B,
        output BUSY, HI, LO
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// An accepted START latches its operands and holds BUSY for a fixed number
// of cycles (MUL_CYCLES or DIV_CYCLES); the result is written into HI/LO on
// the edge that drops BUSY. mthi/mtlo writes are honoured only while idle.
module mdu_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    mdu_sequencer_if.slave  bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN_MUL = 2'd1,
        S_RUN_DIV = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        op_r;
    logic              madd_r;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic              busy_r;
    logic [31:0]       hi_r;
    logic [31:0]       lo_r;

    logic signed [63:0] sprod_s;
    logic        [63:0] uprod_s;
    logic               div_zero_s;
    logic               div_ovf_s;
    logic        [31:0] div_b_s;
    logic signed [31:0] squo_s;
    logic signed [31:0] srem_s;
    logic        [31:0] uquo_s;
    logic        [31:0] urem_s;
    logic        [63:0] res_s;

    // Arithmetic on the latched operands; the divisor is forced to 1 in the
    // zero and overflow cases so the dividers never see an undefined input
    // (those cases are resolved explicitly below).
    always_comb begin
        sprod_s    = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
        uprod_s    = {32'd0, a_r} * {32'd0, b_r};
        div_zero_s = (b_r == 32'd0);
        div_ovf_s  = (op_r == OP_DIV) && (a_r == 32'h8000_0000) && (b_r == 32'hFFFF_FFFF);
        if (div_zero_s || div_ovf_s) begin
            div_b_s = 32'd1;
        end else begin
            div_b_s = b_r;
        end
        squo_s = $signed(a_r) / $signed(div_b_s);
        srem_s = $signed(a_r) % $signed(div_b_s);
        uquo_s = a_r / div_b_s;
        urem_s = a_r % div_b_s;
    end

    // Select the 64-bit {HI,LO} value to commit for the latched operation.
    always_comb begin
        res_s = 64'd0;
        case (op_r)
            OP_MULT: begin
                if (madd_r) begin
                    res_s = {hi_r, lo_r} + 64'(sprod_s);
                end else begin
                    res_s = 64'(sprod_s);
                end
            end
            OP_MULTU: begin
                res_s = uprod_s;
            end
            OP_DIV: begin
                if (div_zero_s) begin
                    res_s = {a_r, 32'hFFFF_FFFF};
                end else if (div_ovf_s) begin
                    res_s = {32'd0, 32'h8000_0000};
                end else begin
                    res_s = {32'(srem_s), 32'(squo_s)};
                end
            end
            OP_DIVU: begin
                if (div_zero_s) begin
                    res_s = {a_r, 32'hFFFF_FFFF};
                end else begin
                    res_s = {urem_s, uquo_s};
                end
            end
            default: begin
                res_s = 64'd0;
            end
        endcase
    end

    // Sequencer FSM: accepts work or mthi/mtlo while idle, counts down the
    // fixed latency while running and commits HI/LO on the final edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            op_r    <= 2'b00;
            madd_r  <= 1'b0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            busy_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.START) begin
                        op_r   <= bus.MDU_OP;
                        madd_r <= bus.madd && (bus.MDU_OP == OP_MULT);
                        a_r    <= bus.A;
                        b_r    <= bus.B;
                        busy_r <= 1'b1;
                        if (bus.MDU_OP[1]) begin
                            cnt_r   <= DIV_LOAD;
                            state_r <= S_RUN_DIV;
                        end else begin
                            cnt_r   <= MUL_LOAD;
                            state_r <= S_RUN_MUL;
                        end
                    end else if (bus.WRITE_ENABLED) begin
                        if (bus.HiLo) begin
                            hi_r <= bus.A;
                        end else begin
                            lo_r <= bus.A;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_RUN_MUL, S_RUN_DIV: begin
                    if (cnt_r == '0) begin
                        hi_r    <= res_s[63:32];
                        lo_r    <= res_s[31:0];
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BUSY = busy_r;
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;

endmodule
